// File: rtl/instruction_fetch_unit.sv
// Fetch stage: turns the next-PC from branching_mechanism into instruction-memory
// requests and hands the fetched word plus its PC downstream over valid/ready.
module instruction_fetch_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_err,
    output logic [31:0] fetch_count
);

    localparam int unsigned     CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t           state,       state_d;
    logic [31:0]      fetch_addr,  fetch_addr_d;
    logic [31:0]      last_pc,     last_pc_d;
    logic             have_last,   have_last_d;
    logic [CNT_W-1:0] cnt,         cnt_d;
    logic             imem_req_d;
    logic [31:0]      instr_out_d;
    logic [31:0]      instr_pc_d;
    logic             instr_valid_d;
    logic             fetch_err_d;
    logic [31:0]      fetch_count_d;

    // fetch_addr is itself a register, so the request address is registered too
    assign imem_addr = fetch_addr;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            fetch_addr  <= '0;
            last_pc     <= '0;
            have_last   <= 1'b0;
            cnt         <= '0;
            imem_req    <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_d;
            fetch_addr  <= fetch_addr_d;
            last_pc     <= last_pc_d;
            have_last   <= have_last_d;
            cnt         <= cnt_d;
            imem_req    <= imem_req_d;
            instr_out   <= instr_out_d;
            instr_pc    <= instr_pc_d;
            instr_valid <= instr_valid_d;
            fetch_err   <= fetch_err_d;
            fetch_count <= fetch_count_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state;
        fetch_addr_d  = fetch_addr;
        last_pc_d     = last_pc;
        have_last_d   = have_last;
        cnt_d         = cnt;
        instr_out_d   = instr_out;
        instr_pc_d    = instr_pc;
        fetch_err_d   = 1'b0;
        fetch_count_d = fetch_count;

        case (state)
            IDLE: begin
                // An unchanged PC after an accepted fetch means the core is halted
                if (!have_last || (pc_in != last_pc)) begin
                    fetch_addr_d = pc_in;
                    cnt_d        = '0;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (pc_in != fetch_addr) begin
                    // Redirect wins over a same-cycle response, which is dropped
                    fetch_addr_d = pc_in;
                    cnt_d        = '0;
                end else if (imem_ready) begin
                    instr_out_d = imem_rdata;
                    instr_pc_d  = fetch_addr;
                    state_d     = VALID;
                end else if (cnt == CNT_LAST) begin
                    cnt_d       = '0;
                    fetch_err_d = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            VALID: begin
                if (instr_ready) begin
                    last_pc_d     = instr_pc;
                    have_last_d   = 1'b1;
                    fetch_count_d = fetch_count + 32'd1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        imem_req_d    = (state_d == REQ);
        instr_valid_d = (state_d == VALID);
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed test-plan scenarios followed by
// randomized traffic, all checked cycle by cycle against a behavioural model.
module tb_instruction_fetch_unit;

    localparam int unsigned TMO = 4;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    instruction_fetch_unit #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_err   (fetch_err),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: "requesting", "holding" and neither means waiting for a new PC
    logic        m_req, m_valid, m_err, m_have;
    logic [31:0] m_addr, m_out, m_pc, m_count, m_last;
    int          m_wait;

    task automatic model_reset();
        m_req = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_have = 1'b0;
        m_addr = '0; m_out = '0; m_pc = '0; m_count = '0; m_last = '0;
        m_wait = 0;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic rdy,
                                input logic [31:0] rd, input logic ird);
        logic err_next;
        err_next = 1'b0;
        if (m_valid) begin
            if (ird) begin
                m_last  = m_pc;
                m_have  = 1'b1;
                m_count = m_count + 32'd1;
                m_valid = 1'b0;
            end
        end else if (m_req) begin
            if (pc != m_addr) begin
                m_addr = pc;
                m_wait = 0;
            end else if (rdy) begin
                m_out   = rd;
                m_pc    = m_addr;
                m_req   = 1'b0;
                m_valid = 1'b1;
            end else begin
                m_wait = m_wait + 1;
                if (m_wait == int'(TMO)) begin
                    err_next = 1'b1;
                    m_wait   = 0;
                end
            end
        end else if (!m_have || pc != m_last) begin
            m_addr = pc;
            m_wait = 0;
            m_req  = 1'b1;
        end
        m_err = err_next;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_req"},    32'(imem_req),    32'(m_req));
        chk({tag, ".imem_addr"},   imem_addr,        m_addr);
        chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(m_valid));
        chk({tag, ".instr_out"},   instr_out,        m_out);
        chk({tag, ".instr_pc"},    instr_pc,         m_pc);
        chk({tag, ".fetch_err"},   32'(fetch_err),   32'(m_err));
        chk({tag, ".fetch_count"}, fetch_count,      m_count);
    endtask

    // Apply inputs for one cycle, advance model at the edge, sample 1 time unit later
    task automatic step(input string tag, input logic [31:0] pc, input logic rdy,
                        input logic [31:0] rd, input logic ird);
        pc_in = pc; imem_ready = rdy; imem_rdata = rd; instr_ready = ird;
        @(posedge clk);
        model_update(pc, rdy, rd, ird);
        #1;
        check_all(tag);
    endtask

    logic [8:0]  err_hist;
    logic [31:0] cur_pc;
    logic [31:0] held_out;

    initial begin
        reset = 1'b0; pc_in = '0; imem_ready = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;

        // Cold start: response on the third request cycle
        step("cold_idle", 32'd0, 1'b0, 32'h0, 1'b0);
        chk("cold_req_up", 32'(imem_req), 32'd1);
        chk("cold_addr", imem_addr, 32'd0);
        step("cold_req1", 32'd0, 1'b0, 32'h0, 1'b0);
        step("cold_req2", 32'd0, 1'b0, 32'h0, 1'b0);
        step("cold_req3", 32'd0, 1'b1, 32'hA5A5_0001, 1'b0);
        chk("cold_valid", 32'(instr_valid), 32'd1);
        chk("cold_out", instr_out, 32'hA5A5_0001);
        chk("cold_pc", instr_pc, 32'd0);
        chk("cold_req_down", 32'(imem_req), 32'd0);

        // Backpressure: pc_in toggles while the consumer stalls
        held_out = instr_out;
        step("bp1", 32'd1, 1'b0, 32'h0, 1'b0);
        step("bp2", 32'd7, 1'b0, 32'h0, 1'b0);
        step("bp3", 32'd1, 1'b0, 32'h0, 1'b0);
        step("bp4", 32'd7, 1'b0, 32'h0, 1'b0);
        step("bp5", 32'd7, 1'b0, 32'h0, 1'b0);
        chk("bp_hold_out", instr_out, 32'hA5A5_0001);
        chk("bp_hold_req", 32'(imem_req), 32'd0);
        step("bp_accept", 32'd7, 1'b0, 32'h0, 1'b1);
        chk("bp_count", fetch_count, 32'd1);
        chk("bp_bubble", 32'(imem_req), 32'd0);
        step("bp_next", 32'd7, 1'b0, 32'h0, 1'b0);
        chk("bp_next_addr", imem_addr, 32'd7);
        chk("bp_next_req", 32'(imem_req), 32'd1);

        // Redirect coincident with a response drops that response
        step("rd_to4", 32'd4, 1'b0, 32'h0, 1'b0);
        chk("rd_addr4", imem_addr, 32'd4);
        step("rd_to20", 32'd20, 1'b1, 32'h0000_DEAD, 1'b0);
        chk("rd_addr20", imem_addr, 32'd20);
        chk("rd_no_dead", 32'(instr_valid), 32'd0);
        step("rd_resp", 32'd20, 1'b1, 32'h1234_5678, 1'b0);
        chk("rd_pc", instr_pc, 32'd20);
        chk("rd_out", instr_out, 32'h1234_5678);
        step("rd_accept", 32'd20, 1'b0, 32'h0, 1'b1);

        // Timeout: nine request cycles with no response
        step("to_start", 32'd24, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            step("to_wait", 32'd24, 1'b0, 32'h0, 1'b0);
            err_hist[k] = fetch_err;
        end
        chk("to_err_pattern", 32'(err_hist), 32'(9'b0_1000_1000));
        chk("to_addr", imem_addr, 32'd24);
        chk("to_req", 32'(imem_req), 32'd1);
        step("to_resp", 32'd24, 1'b1, 32'hC0DE_0018, 1'b0);
        step("to_accept", 32'd24, 1'b0, 32'h0, 1'b1);

        // Halt: PC held at the last accepted address
        step("h_start", 32'd12, 1'b0, 32'h0, 1'b0);
        step("h_resp", 32'd12, 1'b1, 32'hC0DE_000C, 1'b0);
        step("h_accept", 32'd12, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            step("h_hold", 32'd12, 1'b0, 32'h0, 1'b0);
            chk("h_no_req", 32'(imem_req), 32'd0);
        end
        chk("h_count", fetch_count, 32'd4);
        step("h_resume", 32'd13, 1'b0, 32'h0, 1'b0);
        chk("h_resume_req", 32'(imem_req), 32'd1);
        chk("h_resume_addr", imem_addr, 32'd13);

        // Asynchronous reset while requesting, between clock edges
        #3;
        reset = 1'b0;
        #1;
        chk("ar_req", 32'(imem_req), 32'd0);
        chk("ar_valid", 32'(instr_valid), 32'd0);
        chk("ar_err", 32'(fetch_err), 32'd0);
        chk("ar_count", fetch_count, 32'd0);
        chk("ar_addr", imem_addr, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_all("ar_hold");
        reset = 1'b1;

        // Randomized traffic: small PC range so halts and redirects occur often
        cur_pc = 32'd0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) cur_pc = 32'($urandom_range(0, 15));
            step("rand", cur_pc, ($urandom_range(0, 9) < 4), $urandom, ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
